note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
// Sequences the sine_reader for one note at a time. Accepts {note, duration} commands over a
// valid/ready handshake and looks up the note's step size in an external 1-cycle-latency
// frequency ROM. Holds step_size steady while the note plays and issues one generate_next
// pulse per sample period. Counts beat pulses to end the note, then signals done.
// Sits between the song/command source and sine_reader; sample_ready returns from sine_reader.
// PARAMETERS
// SAMPLE_DIV  2083  clk cycles per sample tick (100 MHz / 48 kHz); legal range 2..65535
// NOTE_W      6     width of note number; note 0 = rest
// DUR_W       6     width of duration, in beats
// PORTS
// clk            in   1        system clock, rising edge
// reset          in   1        asynchronous, active-high reset
// play_enable    in   1        1 = run; 0 = pause sample ticks and beat counting
// beat           in   1        one-cycle beat strobe from the tempo divider
// load_valid     in   1        command valid
// load_note      in   NOTE_W   note number of the command
// load_duration  in   DUR_W    duration of the command, in beats
// load_ready     out  1        block can accept a command
// rom_addr       out  NOTE_W   address to the frequency ROM
// rom_step       in   20       ROM data {10b int, 10b frac}, valid 1 cycle after rom_addr
// step_size      out  20       step size to sine_reader
// generate_next  out  1        one-cycle sample request to sine_reader
// sample_ready   in   1        sine_reader has produced the requested sample
// playing        out  1        state == PLAY
// note_done      out  1        one-cycle pulse when a note completes
// overrun        out  1        sticky: a tick fired while the previous request was unanswered
// BEHAVIOUR
// Reset: state=IDLE; load_ready=1; step_size=0; generate_next=0; note_done=0; overrun=0;
//   rom_addr=0; divider=0; beat counter=0; outstanding=0.
//   Reset mid-note aborts immediately with no note_done.
// FSM: IDLE -> FETCH -> LATCH -> PLAY -> DONE -> IDLE.
//  IDLE : load_ready=1. On load_valid&&load_ready, register note into rom_addr and duration
//         into the beat counter, then go to FETCH. When load_valid=0, load_ready stays high.
//  FETCH: one cycle so the ROM can respond. load_ready=0.
//  LATCH: step_size <= (note==0) ? 0 : rom_step. Clear the divider.
//         If duration==0, go to DONE; otherwise go to PLAY.
//  PLAY : divider counts 0..SAMPLE_DIV-1 while play_enable=1 and holds while play_enable=0.
//         generate_next=1 for exactly the one cycle the divider wraps to 0.
//         First tick comes SAMPLE_DIV cycles after entering PLAY.
//         Each beat with play_enable=1 decrements the counter; counter reaching 0 -> DONE.
//         A beat arriving while play_enable=0 is ignored.
//  DONE : note_done=1 for one cycle. step_size stays at its last value (no click).
//         generate_next=0. Go to IDLE.
// Rests (note 0) still emit generate_next ticks with step_size=0.
// Outstanding flag:
//  - set on generate_next; cleared on sample_ready.
//  - If a tick fires while outstanding=1, overrun<=1. overrun is sticky and clears only on reset.
//  - If sample_ready and a new tick land in the same cycle, outstanding stays 1 and there is no overrun.
//  - sample_ready while outstanding=0 is ignored.
// Beat and tick in the same cycle: both take effect. If that beat ends the note, the tick is
//   still emitted and the next state is DONE.
// Divider width = clog2(SAMPLE_DIV). Beat counter is DUR_W bits and only decrements from a
//   nonzero value.
// TESTING (bench uses SAMPLE_DIV=4)
// T1 reset mid-PLAY -> outputs at reset values same cycle; state IDLE; no note_done pulse.
// T2 load note=5 (rom_step=0x27C3E), dur=2; beat every 10 cycles ->
//    step_size=0x27C3E 2 cycles after accept; generate_next every 4 cycles; note_done after 2nd beat.
// T3 load dur=0 -> no generate_next; note_done 3 cycles after accept; load_ready back next cycle.
// T4 note=0, dur=1 -> step_size=0; ticks continue every 4 cycles until beat; rom_step ignored.
// T5 play_enable low for 7 cycles mid-PLAY, with a beat during the pause ->
//    tick spacing stretches by 7 cycles; beat not counted.
// T6 hold sample_ready=0 across two ticks -> overrun=1 and stays 1 through later notes until reset.

Source files
------------

// File: rtl/note_sequencer.sv
// Note sequencer: takes {note, duration} commands, fetches the step size from a
// 1-cycle ROM, ticks sine_reader once per sample period and ends the note on beats.
module note_sequencer #(
  parameter int unsigned SAMPLE_DIV = 2083,
  parameter int unsigned NOTE_W     = 6,
  parameter int unsigned DUR_W      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_enable,
  input  logic              beat,
  input  logic              load_valid,
  input  logic [NOTE_W-1:0] load_note,
  input  logic [DUR_W-1:0]  load_duration,
  output logic              load_ready,
  output logic [NOTE_W-1:0] rom_addr,
  input  logic [19:0]       rom_step,
  output logic [19:0]       step_size,
  output logic              generate_next,
  input  logic              sample_ready,
  output logic              playing,
  output logic              note_done,
  output logic              overrun
);

  localparam int unsigned      DIV_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_PLAY,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [19:0]        step_q, step_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               gen_q, gen_d;
  logic               outst_q, outst_d;
  logic               ovr_q, ovr_d;

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    div_d   = div_q;
    gen_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_valid) begin
          note_d  = load_note;
          cnt_d   = load_duration;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        step_d  = (note_q == '0) ? '0 : rom_step;
        div_d   = '0;
        state_d = (cnt_q == '0) ? S_DONE : S_PLAY;
      end
      S_PLAY: begin
        if (play_enable) begin
          // The tick is registered, so it shows in the cycle the divider reads 0.
          gen_d = (div_q == DIV_LAST);
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
          if (beat && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == DUR_W'(1)) state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new request wins over a same-cycle answer to the previous one.
    outst_d = gen_q ? 1'b1 : (sample_ready ? 1'b0 : outst_q);
    ovr_d   = ovr_q | (gen_q & outst_q & ~sample_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      note_q  <= '0;
      cnt_q   <= '0;
      step_q  <= '0;
      div_q   <= '0;
      gen_q   <= 1'b0;
      outst_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      div_q   <= div_d;
      gen_q   <= gen_d;
      outst_q <= outst_d;
      ovr_q   <= ovr_d;
    end
  end

  assign load_ready    = (state_q == S_IDLE);
  assign rom_addr      = note_q;
  assign step_size     = step_q;
  assign generate_next = gen_q;
  assign playing       = (state_q == S_PLAY);
  assign note_done     = (state_q == S_DONE);
  assign overrun       = ovr_q;

endmodule
